// File: rtl/game_control_fsm.sv
// game_control_fsm: control unit of the memory game.
// Holds the game FSM, the ENTER-key synchroniser / falling-edge detector and the
// tick prescaler that paces the datapath time counter (E2).
// Optional feature macro: GAME_TIMEOUT_EN -- when defined, end_time in USER
// (without end_User) ends the game by timeout; when undefined end_time is ignored.
module game_control_fsm #(
    parameter int TICK_DIV = 50_000_000,
    parameter int ST_W     = 3
) (
    input  logic            CLOCK_50,
    input  logic            RESET,
    input  logic            KEY_ENTER,
    input  logic            end_FPGA,
    input  logic            end_User,
    input  logic            end_time,
    input  logic            win,
    input  logic            match,
    output logic            R1,
    output logic            R2,
    output logic            E1,
    output logic            E2,
    output logic            E3,
    output logic            E4,
    output logic            SEL,
    output logic [ST_W-1:0] state_o
);

    typedef enum logic [ST_W-1:0] {
        ST_INIT   = ST_W'(0),
        ST_SETUP  = ST_W'(1),
        ST_FPGA   = ST_W'(2),
        ST_USER   = ST_W'(3),
        ST_CHECK  = ST_W'(4),
        ST_NEXT   = ST_W'(5),
        ST_RESULT = ST_W'(6)
    } state_t;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] tick_cnt_reg;
    logic [CNT_W-1:0] tick_cnt_next;
    logic             tick;

    // The key is active-low, so every flop of the chain resets to 1 (released).
    logic sync1_reg;
    logic sync2_reg;
    logic key_prev_reg;
    logic enter_p_reg;

`ifndef GAME_TIMEOUT_EN
    // end_time has no effect in this build; keep it visibly consumed.
    logic timeout_unused;
    assign timeout_unused = end_time;
`endif

    // ENTER: two-flop synchroniser, then a registered falling-edge pulse.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            key_prev_reg <= 1'b1;
            enter_p_reg  <= 1'b0;
        end else begin
            sync1_reg    <= KEY_ENTER;
            sync2_reg    <= sync1_reg;
            key_prev_reg <= sync2_reg;
            enter_p_reg  <= key_prev_reg & ~sync2_reg;
        end
    end

    // Prescaler: counts only while the user is playing, held at zero otherwise.
    always_comb begin
        tick_cnt_next = '0;
        tick          = 1'b0;
        if (state_reg == ST_USER) begin
            if (tick_cnt_reg == TICK_LAST) begin
                tick          = 1'b1;
                tick_cnt_next = '0;
            end else begin
                tick_cnt_next = tick_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Prescaler count register.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_next;
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and Moore output decode; E2/E4 are qualified by tick/enter_p.
    always_comb begin
        state_next = state_reg;
        R1  = 1'b0;
        R2  = 1'b0;
        E1  = 1'b0;
        E2  = 1'b0;
        E3  = 1'b0;
        E4  = 1'b0;
        SEL = 1'b0;
        case (state_reg)
            ST_INIT: begin
                R1         = 1'b1;
                R2         = 1'b1;
                state_next = ST_SETUP;
            end
            ST_SETUP: begin
                E1 = 1'b1;
                if (enter_p_reg) begin
                    state_next = ST_FPGA;
                end
            end
            ST_FPGA: begin
                E3 = 1'b1;
                R2 = 1'b1;
                if (end_FPGA) begin
                    state_next = ST_USER;
                end
            end
            ST_USER: begin
                E2 = tick;
                E4 = enter_p_reg;
                // A completed entry takes priority over a simultaneous timeout.
                if (end_User) begin
                    state_next = ST_CHECK;
                end
`ifdef GAME_TIMEOUT_EN
                else if (end_time) begin
                    state_next = ST_RESULT;
                end
`endif
            end
            ST_CHECK: begin
                if (match && !win) begin
                    state_next = ST_NEXT;
                end else begin
                    state_next = ST_RESULT;
                end
            end
            ST_NEXT: begin
                R2         = 1'b1;
                state_next = ST_FPGA;
            end
            ST_RESULT: begin
                SEL = 1'b1;
                if (enter_p_reg) begin
                    state_next = ST_INIT;
                end
            end
            default: begin
                // Unused encodings recover through INIT.
                state_next = ST_INIT;
            end
        endcase
    end

    assign state_o = state_reg;

endmodule

// File: tb/tb_game_control_fsm.sv
// Directed bench for game_control_fsm with TICK_DIV=4: a cycle-by-cycle vector
// table walking a full game, plus hand sequences for reset, key hold, tick
// spacing, loss on mismatch and the timeout option.
module tb_game_control_fsm;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic       end_fpga;
    logic       end_user;
    logic       end_time;
    logic       win;
    logic       match_i;
    logic       r1, r2, e1, e2, e3, e4, sel;
    logic [2:0] state_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_control_fsm #(
        .TICK_DIV (TICK_DIV),
        .ST_W     (3)
    ) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .KEY_ENTER (key),
        .end_FPGA  (end_fpga),
        .end_User  (end_user),
        .end_time  (end_time),
        .win       (win),
        .match     (match_i),
        .R1        (r1),
        .R2        (r2),
        .E1        (e1),
        .E2        (e2),
        .E3        (e3),
        .E4        (e4),
        .SEL       (sel),
        .state_o   (state_o)
    );

    // Expected output words: {state, R1 R2 E1 E2 E3 E4 SEL}
    localparam logic [9:0] O_INIT   = {3'd0, 7'b1100000};
    localparam logic [9:0] O_SETUP  = {3'd1, 7'b0010000};
    localparam logic [9:0] O_FPGA   = {3'd2, 7'b0100100};
    localparam logic [9:0] O_USER   = {3'd3, 7'b0000000};
    localparam logic [9:0] O_USER_T = {3'd3, 7'b0001000};
    localparam logic [9:0] O_CHECK  = {3'd4, 7'b0000000};
    localparam logic [9:0] O_NEXT   = {3'd5, 7'b0100000};
    localparam logic [9:0] O_RESULT = {3'd6, 7'b0000001};

    // in = {KEY_ENTER, end_FPGA, end_User, end_time, win, match}
    typedef struct {
        logic [5:0] in;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[22];

    function automatic logic [9:0] obs();
        return {state_o, r1, r2, e1, e2, e3, e4, sel};
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        key      = 1'b1;
        end_fpga = 1'b0;
        end_user = 1'b0;
        end_time = 1'b0;
        win      = 1'b0;
        match_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick_clk();
        tick_clk();
        rst = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (state_o !== target && n < budget) begin
            tick_clk();
            n++;
        end
        check_val(name, {29'd0, state_o}, {29'd0, target});
    endtask

    task automatic goto_user();
        do_reset();
        wait_state(3'd1, 4, "reach_setup");
        key = 1'b0;
        wait_state(3'd2, 8, "reach_fpga");
        key      = 1'b1;
        end_fpga = 1'b1;
        wait_state(3'd3, 4, "reach_user");
        end_fpga = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int pos;
        int first;
        int last;
        int gap_bad;
        logic [2:0] prev_st;

        // Full-game walk, one clock per entry.
        tbl[0]  = '{6'b100000, O_SETUP};
        tbl[1]  = '{6'b000000, O_SETUP};
        tbl[2]  = '{6'b011000, O_SETUP};   // status flags ignored in SETUP
        tbl[3]  = '{6'b000000, O_SETUP};
        tbl[4]  = '{6'b000000, O_FPGA};    // enter_p seen 3 cycles after the fall
        tbl[5]  = '{6'b101100, O_FPGA};    // end_User/end_time ignored in FPGA
        tbl[6]  = '{6'b110000, O_USER};
        tbl[7]  = '{6'b100000, O_USER};
        tbl[8]  = '{6'b100000, O_USER};
        tbl[9]  = '{6'b100000, O_USER_T};  // first tick, 4th cycle in USER
        tbl[10] = '{6'b100000, O_USER};
        tbl[11] = '{6'b101001, O_CHECK};
        tbl[12] = '{6'b100001, O_NEXT};    // match & !win
        tbl[13] = '{6'b100000, O_FPGA};
        tbl[14] = '{6'b110000, O_USER};
        tbl[15] = '{6'b101011, O_CHECK};
        tbl[16] = '{6'b100011, O_RESULT};  // match & win
        tbl[17] = '{6'b000000, O_RESULT};
        tbl[18] = '{6'b000000, O_RESULT};
        tbl[19] = '{6'b000000, O_RESULT};
        tbl[20] = '{6'b000000, O_INIT};
        tbl[21] = '{6'b100000, O_SETUP};

        // Reset state while RESET is held.
        idle_inputs();
        rst = 1'b1;
        tick_clk();
        tick_clk();
        check_val("reset_outputs", {22'd0, obs()}, {22'd0, O_INIT});
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            {key, end_fpga, end_user, end_time, win, match_i} = tbl[i].in;
            tick_clk();
            $display("vec %0d in=%b out=%b exp=%b", i, tbl[i].in, obs(), tbl[i].exp);
            check_val($sformatf("vec%0d", i), {22'd0, obs()}, {22'd0, tbl[i].exp});
        end

        // RESET asserted mid-USER takes effect before the next edge.
        goto_user();
        tick_clk();
        tick_clk();
        #2;
        rst = 1'b1;
        #1;
        $display("seq reset_mid_user state=%0d r1=%b r2=%b", state_o, r1, r2);
        check_val("reset_async", {26'd0, state_o, r1, r2}, {26'd0, 3'd0, 1'b1, 1'b1});
        tick_clk();
        rst = 1'b0;
        tick_clk();
        $display("seq after_release out=%b", obs());
        check_val("after_release", {22'd0, obs()}, {22'd0, O_SETUP});

        // Key held 10 cycles in SETUP: exactly one SETUP->FPGA move.
        do_reset();
        wait_state(3'd1, 4, "hold_setup");
        key = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            prev_st = state_o;
            tick_clk();
            if (prev_st == 3'd1 && state_o == 3'd2) cnt++;
        end
        key = 1'b1;
        $display("seq key_hold_setup transitions=%0d out=%b", cnt, obs());
        check_val("hold_transitions", cnt, 1);
        check_val("hold_fpga_out", {22'd0, obs()}, {22'd0, O_FPGA});

        // 12 cycles in USER: E2 pulses at offsets 3, 7, 11 after entry.
        goto_user();
        cnt = 0;
        first = -1;
        last = -1;
        gap_bad = 0;
        for (int i = 1; i <= 12; i++) begin
            tick_clk();
            if (e2 === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
                if (last >= 0 && i - last != TICK_DIV) gap_bad++;
                last = i;
            end
        end
        $display("seq ticks count=%0d first=%0d bad_gaps=%0d", cnt, first, gap_bad);
        check_val("tick_count", cnt, 3);
        check_val("tick_first", first, TICK_DIV - 1);
        check_val("tick_gaps", gap_bad, 0);

        // Key held 10 cycles in USER: one E4 pulse on the 3rd cycle.
        goto_user();
        key = 1'b0;
        cnt = 0;
        pos = -1;
        for (int i = 1; i <= 10; i++) begin
            tick_clk();
            if (e4 === 1'b1) begin
                cnt++;
                pos = i;
            end
        end
        key = 1'b1;
        $display("seq e4_hold count=%0d pos=%0d state=%0d", cnt, pos, state_o);
        check_val("e4_count", cnt, 1);
        check_val("e4_pos", pos, 3);
        check_val("e4_stay_user", {29'd0, state_o}, 32'd3);

        // Mismatch: CHECK -> RESULT, then ENTER returns to INIT.
        goto_user();
        end_user = 1'b1;
        match_i  = 1'b0;
        tick_clk();
        check_val("miss_check", {22'd0, obs()}, {22'd0, O_CHECK});
        end_user = 1'b0;
        tick_clk();
        $display("seq mismatch out=%b", obs());
        check_val("miss_result", {22'd0, obs()}, {22'd0, O_RESULT});
        key = 1'b0;
        wait_state(3'd0, 6, "result_to_init");
        check_val("init_out", {22'd0, obs()}, {22'd0, O_INIT});
        key = 1'b1;

        // Timeout without end_User.
        goto_user();
        end_time = 1'b1;
        tick_clk();
        tick_clk();
        $display("seq timeout state=%0d", state_o);
`ifdef GAME_TIMEOUT_EN
        check_val("timeout", {29'd0, state_o}, 32'd6);
`else
        check_val("timeout", {29'd0, state_o}, 32'd3);
`endif

        // Both end_User and end_time: end_User wins.
        goto_user();
        end_time = 1'b1;
        end_user = 1'b1;
        match_i  = 1'b1;
        tick_clk();
        $display("seq both_flags state=%0d", state_o);
        check_val("both_flags", {29'd0, state_o}, 32'd4);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
